e_mdu: RTL and testbench



---
 rtl/e_mdu_pkg.sv | 47 ++++
 rtl/e_mdu_if.sv | 16 +
 rtl/e_mdu.sv | 82 ++++++++
 tb/tb_e_mdu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MD op codes and the multiply/divide arithmetic used by the E-stage MDU.
// Decode and the hazard unit import the same op codes.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6
  } md_op_e;

  // Returns the full 64-bit product as {hi, lo}.
  function automatic logic [63:0] md_mul(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // quotient truncates toward zero and the remainder follows the dividend;
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] md_div(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
    quo   = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    rem   = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    if (a_neg ^ b_neg) quo = ~quo + 32'd1;
    if (a_neg)         rem = ~rem + 32'd1;
    return {rem, quo};
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage to MDU bundle: operation request in, Busy and architectural HI/LO out.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic        start;
  logic        req;
  md_op_e      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, req, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, req, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes the result on the
// accepting edge and holds it in temp registers until the busy countdown ends.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, lo_q;
  logic [63:0]      temp_q, temp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_q, commit_d;
  logic             busy;
  logic             accept;

  assign busy   = (cnt_q != '0);
  assign accept = mdu.start && !mdu.req && !busy;

  // NOTE: every signal driven here gets a default first, so no latch is inferred
  // for op codes that do not load the temp registers.
  always_comb begin
    temp_d   = '0;
    cnt_d    = '0;
    commit_d = 1'b0;
    unique case (mdu.md_op)
      MDOP_MULT, MDOP_MULTU: begin
        temp_d   = md_mul(mdu.a, mdu.b, mdu.md_op == MDOP_MULT);
        cnt_d    = CNT_W'(MULT_CYCLES);
        commit_d = 1'b1;
      end
      MDOP_DIV, MDOP_DIVU: begin
        temp_d   = md_div(mdu.a, mdu.b, mdu.md_op == MDOP_DIV);
        cnt_d    = CNT_W'(DIV_CYCLES);
        commit_d = (mdu.b != 32'd0);
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register sees the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      temp_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else if (busy) begin
      // Req and Start are ignored here: the in-flight op is already committed.
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && commit_q) begin
        hi_q <= temp_q[63:32];
        lo_q <= temp_q[31:0];
      end
    end else if (accept) begin
      unique case (mdu.md_op)
        MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: begin
          temp_q   <= temp_d;
          cnt_q    <= cnt_d;
          commit_q <= commit_d;
        end
        MDOP_MTHI: hi_q <= mdu.a;
        MDOP_MTLO: lo_q <= mdu.a;
        default: ;
      endcase
    end
  end

  assign mdu.busy = busy;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases with literal expectations plus
// randomized traffic compared every cycle against a cycle-count reference model.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e_mdu_if mdu_if ();

  e_mdu #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk  (clk),
    .reset(rst),
    .mdu  (mdu_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int busy_seen = 0;
  bit checks_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an op accepted on edge e makes cycles e+1..e+N busy and
  // its result lands on edge e+N.
  int          cyc = 0;
  int          busy_end = -1;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi, p_lo;
  bit          p_ok;

  always @(posedge clk) begin
    longint      sa, sb;
    logic [63:0] prod;
    sa = longint'($signed(mdu_if.a));
    sb = longint'($signed(mdu_if.b));
    if (rst) begin
      m_hi = '0;
      m_lo = '0;
      busy_end = -1;
    end else begin
      if (cyc == busy_end && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      if (mdu_if.start && !mdu_if.req && !(cyc <= busy_end)) begin
        case (mdu_if.md_op)
          MDOP_MULT: begin
            prod = 64'(sa * sb);
            {p_hi, p_lo} = prod; p_ok = 1; busy_end = cyc + MULT_C;
          end
          MDOP_MULTU: begin
            prod = {32'd0, mdu_if.a} * {32'd0, mdu_if.b};
            {p_hi, p_lo} = prod; p_ok = 1; busy_end = cyc + MULT_C;
          end
          MDOP_DIV: begin
            p_ok = (sb != 0);
            if (p_ok) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            busy_end = cyc + DIV_C;
          end
          MDOP_DIVU: begin
            p_ok = (mdu_if.b != 0);
            if (p_ok) begin p_lo = mdu_if.a / mdu_if.b; p_hi = mdu_if.a % mdu_if.b; end
            busy_end = cyc + DIV_C;
          end
          MDOP_MTHI: m_hi = mdu_if.a;
          MDOP_MTLO: m_lo = mdu_if.a;
          default: ;
        endcase
      end
    end
    cyc++;
    if (rst) checks_on = 1'b1;
  end

  always @(negedge clk) begin
    if (checks_on) begin
      check("busy", 32'(mdu_if.busy), 32'(cyc <= busy_end));
      check("hi", mdu_if.hi, m_hi);
      check("lo", mdu_if.lo, m_lo);
      if (mdu_if.busy) busy_seen++;
    end
  end

  task automatic drive(input logic rs, input logic st, input logic rq, input md_op_e op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = rs;
    mdu_if.start = st;
    mdu_if.req = rq;
    mdu_if.md_op = op;
    mdu_if.a = a;
    mdu_if.b = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, MDOP_NONE, 32'd0, 32'd0);
  endtask

  // Issue one op, let it finish, then pin busy length and HI/LO to literals.
  task automatic run(input string tag, input md_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_busy,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    #1 busy_seen = 0;
    drive(1'b0, 1'b1, 1'b0, op, a, b);
    idle(exp_busy + 3);
    #1;
    check({tag, " busy cycles"}, 32'(busy_seen), 32'(exp_busy));
    check({tag, " HI"}, mdu_if.hi, exp_hi);
    check({tag, " LO"}, mdu_if.lo, exp_lo);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    mdu_if.start = 1'b0;
    mdu_if.req   = 1'b0;
    mdu_if.md_op = MDOP_NONE;
    mdu_if.a     = '0;
    mdu_if.b     = '0;
    drive(1'b1, 1'b0, 1'b0, MDOP_NONE, 32'd0, 32'd0);
    idle(2);
    #1;
    check("reset busy", 32'(mdu_if.busy), 32'd0);
    check("reset HI", mdu_if.hi, 32'd0);
    check("reset LO", mdu_if.lo, 32'd0);

    run("MULT -2*3",  MDOP_MULT,  32'hFFFF_FFFE, 32'd3, MULT_C, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("MULTU",      MDOP_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_C, 32'h0000_0002, 32'hFFFF_FFFA);
    run("DIV -7/2",   MDOP_DIV,   32'hFFFF_FFF9, 32'd2, DIV_C,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("DIVU 7/2",   MDOP_DIVU,  32'd7,         32'd2, DIV_C,  32'd1,         32'd3);
    run("DIV ovf",    MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_C, 32'd0, 32'h8000_0000);

    // MTHI then MTLO on consecutive edges, no busy.
    #1 busy_seen = 0;
    drive(1'b0, 1'b1, 1'b0, MDOP_MTHI, 32'h1234_5678, 32'd0);
    drive(1'b0, 1'b1, 1'b0, MDOP_MTLO, 32'h9ABC_DEF0, 32'd0);
    #1 check("MTHI next cycle", mdu_if.hi, 32'h1234_5678);
    idle(1);
    #1;
    check("MTLO next cycle", mdu_if.lo, 32'h9ABC_DEF0);
    check("MT busy", 32'(busy_seen), 32'd0);

    // Req on the accept edge cancels the op.
    #1 busy_seen = 0;
    drive(1'b0, 1'b1, 1'b1, MDOP_MULT, 32'd5, 32'd5);
    idle(7);
    #1;
    check("Req cancel busy", 32'(busy_seen), 32'd0);
    check("Req cancel HI", mdu_if.hi, 32'h1234_5678);
    check("Req cancel LO", mdu_if.lo, 32'h9ABC_DEF0);

    // Req at t+3 and Start at t+4 of an in-flight DIVU are both ignored.
    #1 busy_seen = 0;
    drive(1'b0, 1'b1, 1'b0, MDOP_DIVU, 32'd100, 32'd7);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, MDOP_NONE, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, MDOP_MULT, 32'd5, 32'd5);
    idle(10);
    #1;
    check("inflight busy", 32'(busy_seen), 32'(DIV_C));
    check("inflight HI", mdu_if.hi, 32'd2);
    check("inflight LO", mdu_if.lo, 32'd14);

    // Divide by zero: full busy window, HI/LO unchanged.
    drive(1'b0, 1'b1, 1'b0, MDOP_MTHI, 32'h11, 32'd0);
    drive(1'b0, 1'b1, 1'b0, MDOP_MTLO, 32'h22, 32'd0);
    run("DIV by 0", MDOP_DIV, 32'd1234, 32'd0, DIV_C, 32'h11, 32'h22);

    // Reset at t+2 of a MULT discards the pending product.
    drive(1'b0, 1'b1, 1'b0, MDOP_MULT, 32'd3, 32'd4);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, MDOP_NONE, 32'd0, 32'd0);
    idle(1);
    #1;
    check("mid reset busy", 32'(mdu_if.busy), 32'd0);
    check("mid reset HI", mdu_if.hi, 32'd0);
    check("mid reset LO", mdu_if.lo, 32'd0);
    idle(8);
    #1 check("mid reset LO later", mdu_if.lo, 32'd0);

    // Randomized traffic, checked each cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0,
            md_op_e'($urandom_range(0, 6)),
            rnd_operand(), rnd_operand());
    end
    idle(DIV_C + 2);

    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
